// File: rtl/seq_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding and
// the FSM state type used by the top level.
package seq_pattern_tx_pkg;

  // State encodings; the receiving detectors use the same values.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Encoding 3 is named so the FSM can recover from it explicitly.
  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SHIFT   = ST_SHIFT,
    DONE    = ST_DONE,
    ILLEGAL = 2'd3
  } state_t;

endpackage

// File: rtl/seq_shift_reg.sv
// Parallel-load, shift-left register. Zeros enter at the LSB, so after
// PAT_W shifts the register is empty and msb reads 0.
module seq_shift_reg #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [PAT_W-1:0] din,
  output logic             msb
);

  logic [PAT_W-1:0] data_reg;

  // Load has priority over shift; the MSB is the bit currently on the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= din;
    end else if (shift) begin
      data_reg <= {data_reg[PAT_W-2:0], 1'b0};
    end
  end

  assign msb = data_reg[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a latched pattern MSB-first, one bit per
// clock, repeated reps times back-to-back. x comes straight from the shift
// register flop; valid and done are registered from the next-state value.
module seq_pattern_tx
  import seq_pattern_tx_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             x,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(PAT_W - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
  logic [PAT_W-1:0] shadow_reg, shadow_next;
  logic             valid_reg, done_reg;

  logic             sr_load;
  logic             sr_shift;
  logic [PAT_W-1:0] sr_din;

  seq_shift_reg #(.PAT_W(PAT_W)) u_shift (
    .clk   (clk),
    .rst   (rst),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .msb   (x)
  );

  // State, counters, shadow pattern and registered flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      rep_cnt_reg <= '0;
      shadow_reg  <= '0;
      valid_reg   <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bit_cnt_reg <= bit_cnt_next;
      rep_cnt_reg <= rep_cnt_next;
      shadow_reg  <= shadow_next;
      valid_reg   <= (state_next == SHIFT);
      done_reg    <= (state_next == DONE);
    end
  end

  // Next-state logic and shift register control.
  always_comb begin
    state_next   = state_reg;
    bit_cnt_next = bit_cnt_reg;
    rep_cnt_next = rep_cnt_reg;
    shadow_next  = shadow_reg;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    sr_din       = shadow_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          if (reps != '0) begin
            state_next   = SHIFT;
            shadow_next  = pattern;
            rep_cnt_next = reps;
            bit_cnt_next = '0;
            sr_load      = 1'b1;
            sr_din       = pattern;
          end else begin
            // Nothing to send: go straight to the done pulse.
            state_next = DONE;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          // Cancel wins over end-of-pattern; empty the register so x drops.
          state_next   = IDLE;
          bit_cnt_next = '0;
          rep_cnt_next = '0;
          sr_load      = 1'b1;
          sr_din       = '0;
        end else if (bit_cnt_reg == LAST_BIT) begin
          bit_cnt_next = '0;
          if (rep_cnt_reg > REP_W'(1)) begin
            // Reload for the next repetition with no idle gap.
            rep_cnt_next = rep_cnt_reg - 1'b1;
            sr_load      = 1'b1;
            sr_din       = shadow_reg;
          end else begin
            // Final shift leaves the register all-zero, so x returns to 0.
            state_next   = DONE;
            rep_cnt_next = '0;
            sr_shift     = 1'b1;
          end
        end else begin
          bit_cnt_next = bit_cnt_reg + 1'b1;
          sr_shift     = 1'b1;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
        sr_load    = 1'b1;
        sr_din     = '0;
      end
    endcase
  end

  assign valid = valid_reg;
  assign done  = done_reg;
  assign busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Self-checking bench for seq_pattern_tx: a table of complete transfers plus
// hand-written sequences for async reset, held start, abort and loop-back.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int REP_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic [3:0] pattern;
  logic [3:0] reps;
  logic       x, valid, busy, done;

  int tests = 0;
  int fails = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .reps    (reps),
    .x       (x),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pat;
    logic [3:0]  rep;
    logic [15:0] exp_bits;
    int          exp_nvalid;
    int          exp_nbusy;
    int          exp_done_cyc;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One transfer: start for one cycle, then observe at each negedge until
  // busy falls. Inputs are scrambled right after acceptance.
  task automatic run_transfer(input logic [3:0] p, input logic [3:0] r,
                              output logic [15:0] bits, output int nvalid,
                              output int nbusy, output int done_cyc,
                              output int ndone, output int xleak,
                              output int timed_out);
    int cyc;
    bits = '0; nvalid = 0; nbusy = 0; done_cyc = 0; ndone = 0; xleak = 0;
    timed_out = 1;
    @(negedge clk);
    pattern = p; reps = r; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    pattern = 4'($urandom);
    reps    = 4'($urandom);
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (valid) begin
        bits = {bits[14:0], x};
        nvalid++;
      end else if (x) begin
        xleak++;
      end
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      if (!busy) begin
        timed_out = 0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy), 32'd0);
  endtask

  logic [15:0] g_bits;
  int g_nvalid, g_nbusy, g_done_cyc, g_ndone, g_xleak, g_to;
  logic [6:0] r4_x, r4_v, r4_b, r4_d;
  logic [7:0] r5_x, r5_v, r5_b, r5_d;
  logic [3:0] hist;
  logic [15:0] flag_mask;
  int since, nflags, sb_idx, sb_err;
  logic [3:0] lb_pat;

  initial begin
    vecs[0] = '{pat: 4'b1010, rep: 4'd2, exp_bits: 16'h00AA, exp_nvalid: 8,  exp_nbusy: 9,  exp_done_cyc: 9};
    vecs[1] = '{pat: 4'b1111, rep: 4'd0, exp_bits: 16'h0000, exp_nvalid: 0,  exp_nbusy: 1,  exp_done_cyc: 1};
    vecs[2] = '{pat: 4'b1101, rep: 4'd1, exp_bits: 16'h000D, exp_nvalid: 4,  exp_nbusy: 5,  exp_done_cyc: 5};
    vecs[3] = '{pat: 4'b0110, rep: 4'd3, exp_bits: 16'h0666, exp_nvalid: 12, exp_nbusy: 13, exp_done_cyc: 13};
    vecs[4] = '{pat: 4'b1001, rep: 4'd4, exp_bits: 16'h9999, exp_nvalid: 16, exp_nbusy: 17, exp_done_cyc: 17};
    vecs[5] = '{pat: 4'b0001, rep: 4'd1, exp_bits: 16'h0001, exp_nvalid: 4,  exp_nbusy: 5,  exp_done_cyc: 5};

    rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0; reps = '0;
    #12;
    check("reset_outputs", 32'({x, valid, busy, done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", 32'({x, valid, busy, done}), 32'd0);

    // Table-driven complete transfers.
    for (int i = 0; i < 6; i++) begin
      run_transfer(vecs[i].pat, vecs[i].rep, g_bits, g_nvalid, g_nbusy, g_done_cyc, g_ndone, g_xleak, g_to);
      $display("[TB] vec %0d pattern=%b reps=%0d bits=%h valid=%0d busy=%0d done@%0d",
               i, vecs[i].pat, vecs[i].rep, g_bits, g_nvalid, g_nbusy, g_done_cyc);
      check($sformatf("vec%0d_timeout", i), 32'(g_to), 32'd0);
      check($sformatf("vec%0d_bits", i), 32'(g_bits), 32'(vecs[i].exp_bits));
      check($sformatf("vec%0d_nvalid", i), 32'(g_nvalid), 32'(vecs[i].exp_nvalid));
      check($sformatf("vec%0d_nbusy", i), 32'(g_nbusy), 32'(vecs[i].exp_nbusy));
      check($sformatf("vec%0d_done_cyc", i), 32'(g_done_cyc), 32'(vecs[i].exp_done_cyc));
      check($sformatf("vec%0d_ndone", i), 32'(g_ndone), 32'd1);
      check($sformatf("vec%0d_xleak", i), 32'(g_xleak), 32'd0);
    end

    // Async reset mid-SHIFT, between clock edges.
    @(negedge clk);
    pattern = 4'b1010; reps = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_state", 32'({x, valid, busy, done}), 32'b1110);
    #2 rst = 1'b1;
    #1 check("async_rst_outputs", 32'({x, valid, busy, done}), 32'd0);
    #1 rst = 1'b0;
    run_transfer(4'b1100, 4'd1, g_bits, g_nvalid, g_nbusy, g_done_cyc, g_ndone, g_xleak, g_to);
    $display("[TB] post-reset transfer bits=%h valid=%0d", g_bits, g_nvalid);
    check("post_rst_bits", 32'(g_bits), 32'h000C);
    check("post_rst_nvalid", 32'(g_nvalid), 32'd4);

    // start held high; pattern changed mid-transfer.
    @(negedge clk);
    pattern = 4'b1101; reps = 4'd1; start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 7; c++) begin
      r4_x[6-c] = x; r4_v[6-c] = valid; r4_b[6-c] = busy; r4_d[6-c] = done;
      if (c == 1) pattern = 4'b0000;
      if (c == 4) pattern = 4'b1101;
      @(negedge clk);
    end
    start = 1'b0;
    $display("[TB] held start x=%b valid=%b busy=%b done=%b", r4_x, r4_v, r4_b, r4_d);
    check("held_x", 32'(r4_x), 32'b1101001);
    check("held_valid", 32'(r4_v), 32'b1111001);
    check("held_busy", 32'(r4_b), 32'b1111101);
    check("held_done", 32'(r4_d), 32'b0000100);
    wait_idle("held_wait_idle");

    // Abort on the third bit.
    @(negedge clk);
    pattern = 4'b1011; reps = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8; c++) begin
      r5_x[7-c] = x; r5_v[7-c] = valid; r5_b[7-c] = busy; r5_d[7-c] = done;
      abort = (c == 2);
      @(negedge clk);
    end
    abort = 1'b0;
    $display("[TB] abort x=%b valid=%b busy=%b done=%b", r5_x, r5_v, r5_b, r5_d);
    check("abort_x", 32'(r5_x), 32'b10100000);
    check("abort_valid", 32'(r5_v), 32'b11100000);
    check("abort_busy", 32'(r5_b), 32'b11100000);
    check("abort_done", 32'(r5_d), 32'b00000000);

    // Loop-back into a negedge-sampling, non-overlapping 1010 detector.
    lb_pat = 4'b1010;
    hist = '0; flag_mask = '0; since = 0; nflags = 0; sb_idx = 0; sb_err = 0;
    @(negedge clk);
    pattern = lb_pat; reps = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (valid) begin
        if (x !== lb_pat[3 - (sb_idx % 4)]) sb_err++;
        sb_idx++;
      end
      hist = {hist[2:0], x};
      since++;
      if (hist == 4'b1010 && since >= 4) begin
        flag_mask[c] = 1'b1;
        nflags++;
        since = 0;
      end
      @(negedge clk);
    end
    $display("[TB] loopback bits=%0d flags=%0d mask=%h", sb_idx, nflags, flag_mask);
    check("lb_bit_order", 32'(sb_err), 32'd0);
    check("lb_nbits", 32'(sb_idx), 32'd12);
    check("lb_nflags", 32'(nflags), 32'd3);
    check("lb_flag_pos", 32'(flag_mask), 32'h1110);
    check("lb_idle_end", 32'({x, valid, busy, done}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
